// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared state encoding and frame constants for the byte-stream bootloader.
package prog_loader_pkg;

    typedef enum logic [2:0] {
        S_LEN,
        S_DATA,
        S_CKSUM,
        S_DONE,
        S_ERR
    } loader_state_t;

    localparam int LOADER_LEN_BYTES = 4;

endpackage

// File: rtl/prog_loader_byte_packer.sv
// prog_loader_byte_packer: gathers 4 bytes little-endian into a word; o_word_valid marks the 4th byte.
module prog_loader_byte_packer
    import prog_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_clr,
    input  logic        i_valid,
    input  logic [7:0]  i_data,
    output logic [31:0] o_word,
    output logic        o_word_valid,
    output logic [1:0]  o_byte_cnt
);

    logic [23:0] r_sh;
    logic [1:0]  r_cnt;

    // The 4th byte completes the word combinationally so the caller can register it on the same edge.
    assign o_word       = {i_data, r_sh};
    assign o_word_valid = i_valid & (r_cnt == 2'(LOADER_LEN_BYTES - 1));
    assign o_byte_cnt   = r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh  <= '0;
            r_cnt <= '0;
        end else if (i_clr) begin
            r_sh  <= '0;
            r_cnt <= '0;
        end else if (i_valid) begin
            r_sh  <= {i_data, r_sh[23:8]};
            r_cnt <= r_cnt + 2'd1;
        end
    end

endmodule

// File: rtl/prog_loader.sv
// prog_loader: framed UART byte stream -> imem program writes; holds the core in reset until a frame loads.
// Define PROG_LOADER_CKSUM_EN to require a trailing 8-bit sum byte over LEN+DATA.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter int          MAX_WORDS    = 4096,
    parameter int          IDLE_TIMEOUT = 1_000_000
) (
    input  logic        clk,
    input  logic        start,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    input  logic        reload,
    output logic        prog_en,
    output logic [31:0] prog_addr,
    output logic [31:0] prog_data,
    output logic        cpu_start,
    output logic        load_done,
    output logic        load_err
);

    localparam int WW = $clog2(MAX_WORDS + 1);

`ifdef PROG_LOADER_CKSUM_EN
    localparam loader_state_t L_TAIL = S_CKSUM;
`else
    localparam loader_state_t L_TAIL = S_DONE;
`endif

    loader_state_t r_state, w_next;
    logic [WW-1:0] r_word_idx, r_len;
    logic          r_prog_en, r_cpu_start;
    logic [31:0]   r_prog_addr, r_prog_data;
    logic          w_xfer, w_pack_valid, w_word_valid, w_last, w_timeout, w_cksum_ok;
    logic [31:0]   w_word;
    logic [1:0]    w_byte_cnt;

    assign rx_ready     = (r_state == S_LEN) | (r_state == S_DATA) | (r_state == S_CKSUM);
    assign w_xfer       = rx_valid & rx_ready & ~reload;
    assign w_pack_valid = w_xfer & ((r_state == S_LEN) | (r_state == S_DATA));
    assign w_last       = r_word_idx == r_len - WW'(1);
    assign prog_en      = r_prog_en;
    assign prog_addr    = r_prog_addr;
    assign prog_data    = r_prog_data;
    assign cpu_start    = r_cpu_start;
    assign load_done    = r_state == S_DONE;
    assign load_err     = r_state == S_ERR;

    prog_loader_byte_packer u_packer (
        .clk          (clk),
        .rst_n        (start),
        .i_clr        (reload),
        .i_valid      (w_pack_valid),
        .i_data       (rx_data),
        .o_word       (w_word),
        .o_word_valid (w_word_valid),
        .o_byte_cnt   (w_byte_cnt)
    );

`ifdef PROG_LOADER_CKSUM_EN
    logic [7:0] r_sum;
    assign w_cksum_ok = rx_data == r_sum;
    always_ff @(posedge clk or negedge start) begin
        if (!start)
            r_sum <= '0;
        else if (reload)
            r_sum <= '0;
        else if (w_pack_valid)
            r_sum <= r_sum + rx_data;
    end
`else
    assign w_cksum_ok = 1'b0;
`endif

    generate
        if (IDLE_TIMEOUT > 0) begin : g_timeout
            localparam int GW = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
            logic [GW-1:0] r_gap;
            logic          w_mid, w_idle;
            // Before the first LEN byte the link may sit idle forever.
            assign w_mid     = (r_state == S_DATA) | (r_state == S_CKSUM) |
                               ((r_state == S_LEN) & (w_byte_cnt != 2'd0));
            assign w_idle    = w_mid & ~w_xfer & ~reload;
            assign w_timeout = w_idle & (r_gap == GW'(IDLE_TIMEOUT - 1));
            always_ff @(posedge clk or negedge start) begin
                if (!start)
                    r_gap <= '0;
                else
                    r_gap <= w_idle ? r_gap + GW'(1) : '0;
            end
        end else begin : g_no_timeout
            assign w_timeout = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or negedge start) begin
        if (!start)
            r_state <= S_LEN;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (reload)
            w_next = S_LEN;
        else if (w_timeout)
            w_next = S_ERR;
        else if (w_word_valid && r_state == S_LEN)
            w_next = (w_word > 32'(MAX_WORDS)) ? S_ERR : (w_word == 32'd0) ? L_TAIL : S_DATA;
        else if (w_word_valid && r_state == S_DATA && w_last)
            w_next = L_TAIL;
        else if (w_xfer && r_state == S_CKSUM)
            w_next = w_cksum_ok ? S_DONE : S_ERR;
    end

    always_ff @(posedge clk or negedge start) begin
        if (!start) begin
            r_word_idx  <= '0;
            r_len       <= '0;
            r_prog_en   <= 1'b0;
            r_prog_addr <= '0;
            r_prog_data <= '0;
            r_cpu_start <= 1'b0;
        end else begin
            r_prog_en   <= 1'b0;
            r_cpu_start <= ~reload & (r_state == S_DONE);
            if (reload) begin
                r_word_idx <= '0;
                r_len      <= '0;
            end else if (w_word_valid && r_state == S_LEN) begin
                r_word_idx <= '0;
                r_len      <= w_word[WW-1:0];
            end else if (w_word_valid && r_state == S_DATA) begin
                r_prog_en   <= 1'b1;
                r_prog_addr <= BASE_ADDR + (32'(r_word_idx) << 2);
                r_prog_data <= w_word;
                r_word_idx  <= r_word_idx + WW'(1);
            end
        end
    end

endmodule
